// File: rtl/bp_pkg.sv
// Shared types and helpers for the 2-bit branch predictor table.
// Saturating counter arithmetic lives here so every user agrees on it.
package bp_pkg;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_t;

  typedef logic [1:0] ctr2_t;

  localparam int    BP_INDEX_W  = 6;
  localparam ctr2_t BP_INIT_CTR = 2'b10;

  function automatic ctr2_t sat_inc(ctr2_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr2_t sat_dec(ctr2_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bp_counter_ram.sv
// 1R/1W counter table, registered write-first read, array not reset.
// rd_force overrides the read register while the table is being swept.
module bp_counter_ram
  import bp_pkg::*;
#(
  parameter int    INDEX_W = BP_INDEX_W,
  parameter ctr2_t RST_VAL = BP_INIT_CTR
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [INDEX_W-1:0] rd_addr,
  input  logic               rd_force,
  input  ctr2_t              force_val,
  output ctr2_t              rd_q,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_addr,
  input  ctr2_t              wr_data
);

  localparam int DEPTH = 1 << INDEX_W;

  ctr2_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rd_q <= RST_VAL;
    else if (rd_force)
      rd_q <= force_val;
    else if (we && wr_addr == rd_addr)
      rd_q <= wr_data;
    else
      rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Branch predictor table controller: init sweep FSM, EX copy, updates.
// Define BP_STATS_EN to add branch/mispredict statistics counters.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int    INDEX_W  = BP_INDEX_W,
  parameter ctr2_t INIT_CTR = BP_INIT_CTR
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        flush_req,
  input  logic [15:0] pc_IF,
  input  logic [15:0] pc_EX,
  input  logic        branch_EX,
  input  logic        branch_result_EX,
  output logic        branch_predict_ID,
  output logic        ready
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam logic [INDEX_W-1:0] IDX_MAX = '1;

  bp_state_t          state, state_nxt;
  logic [INDEX_W-1:0] idx, idx_nxt;
  ctr2_t              rd_q;
  ctr2_t              ex_q;
  logic               in_init;
  logic               upd;
  logic               we;
  logic [INDEX_W-1:0] wr_addr;
  ctr2_t              wr_data;
  logic               unused_pc;

  assign unused_pc = ^{pc_IF[15:INDEX_W], pc_EX[15:INDEX_W]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BP_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      BP_INIT: begin
        if (flush_req) begin
          idx_nxt = '0;
        end else begin
          idx_nxt = idx + 1'b1;
          if (idx == IDX_MAX) state_nxt = BP_RUN;
        end
      end
      BP_RUN: begin
        if (flush_req) begin
          state_nxt = BP_INIT;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = BP_INIT;
        idx_nxt   = '0;
      end
    endcase
  end

  assign in_init = (state == BP_INIT);
  // A flush in the same cycle drops the update.
  assign upd     = !in_init && branch_EX && !flush_req;
  assign we      = in_init || upd;
  assign wr_addr = in_init ? idx : pc_EX[INDEX_W-1:0];

  always_comb begin
    wr_data = INIT_CTR;
    if (!in_init)
      wr_data = branch_result_EX ? sat_inc(ex_q) : sat_dec(ex_q);
  end

  bp_counter_ram #(
    .INDEX_W (INDEX_W),
    .RST_VAL (INIT_CTR)
  ) u_ram (
    .clk       (clk),
    .rstn      (rstn),
    .rd_addr   (pc_IF[INDEX_W-1:0]),
    .rd_force  (in_init),
    .force_val (INIT_CTR),
    .rd_q      (rd_q),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ex_q <= INIT_CTR;
    else if (!stall)
      ex_q <= rd_q;
  end

  assign branch_predict_ID = rd_q[1];
  assign ready             = (state == BP_RUN);

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (ex_q[1] != branch_result_EX && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Randomized bench for bp_table_ctrl against a cycle-level table model.
// Define BP_STATS_EN to also cover the statistics counters.
module tb_bp_table_ctrl;

  localparam int N    = 64;
  localparam int INIT = 2;

  logic        clk = 0;
  logic        rstn = 1;
  logic        stall = 0;
  logic        flush_req = 0;
  logic [15:0] pc_IF = 0;
  logic [15:0] pc_EX = 0;
  logic        branch_EX = 0;
  logic        branch_result_EX = 0;
  logic        branch_predict_ID;
  logic        ready;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  bp_table_ctrl dut (
    .clk               (clk),
    .rstn              (rstn),
    .stall             (stall),
    .flush_req         (flush_req),
    .pc_IF             (pc_IF),
    .pc_EX             (pc_EX),
    .branch_EX         (branch_EX),
    .branch_result_EX  (branch_result_EX),
    .branch_predict_ID (branch_predict_ID),
    .ready             (ready)
`ifdef BP_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  int          mtab [N];
  int          m_rd;
  int          m_ex;
  int          m_left;
  logic [31:0] m_br;
  logic [31:0] m_mp;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Table model: counts sweep cycles left instead of tracking FSM state.
  task automatic model_step();
    int old_rd = m_rd;
    int pi = int'(pc_IF) % N;
    int pe = int'(pc_EX) % N;
    int v;
    if (m_left > 0) begin
      m_rd = INIT;
      if (flush_req) m_left = N;
      else begin
        m_left--;
        if (m_left == 0)
          for (int i = 0; i < N; i++) mtab[i] = INIT;
      end
    end else begin
      if (branch_EX && !flush_req) begin
        if (branch_result_EX) v = (m_ex == 3) ? 3 : m_ex + 1;
        else                  v = (m_ex == 0) ? 0 : m_ex - 1;
        if (m_br != '1) m_br++;
        if (((m_ex >> 1) & 1) != int'(branch_result_EX) && m_mp != '1)
          m_mp++;
        mtab[pe] = v;
      end
      m_rd = mtab[pi];
      if (flush_req) m_left = N;
    end
    if (!stall) m_ex = old_rd;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("pred", {31'b0, branch_predict_ID}, (m_rd >> 1) & 1);
    check("ready", {31'b0, ready}, (m_left == 0) ? 1 : 0);
`ifdef BP_STATS_EN
    check("stat_br", stat_branches, m_br);
    check("stat_mp", stat_mispredicts, m_mp);
`endif
  endtask

  task automatic idle(int n);
    branch_EX = 0;
    flush_req = 0;
    stall = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rstn = 0;
    branch_EX = 0;
    flush_req = 0;
    stall = 0;
    #2;
    m_left = N;
    m_rd = INIT;
    m_ex = INIT;
    m_br = 0;
    m_mp = 0;
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_pred", {31'b0, branch_predict_ID}, 1);
    @(posedge clk);
    #1;
    rstn = 1;
  endtask

  task automatic wait_ready(string tag);
    int cnt = 0;
    while (!ready && cnt < 200) begin
      cycle();
      cnt++;
    end
    check(tag, cnt, 64);
  endtask

  task automatic br(int idx, bit t);
    pc_EX = 16'(idx) | 16'($urandom_range(0, 1023) << 6);
    branch_EX = 1;
    branch_result_EX = t;
    cycle();
    branch_EX = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mtab[i] = 0;
    #1;
    do_reset();
    wait_ready("rst_lat");

    for (int i = 0; i < N; i++) begin
      pc_IF = 16'(i) | 16'($urandom_range(0, 1023) << 6);
      cycle();
    end

    // Predictor stays taken at index 20: 7 taken, 3 not taken.
    pc_IF = 16'd20;
    idle(2);
    for (int k = 0; k < 10; k++) br(40 + k, k < 7);
`ifdef BP_STATS_EN
    check("stat10", stat_branches, 10);
    check("stat3", stat_mispredicts, 3);
`endif
    flush_req = 1;
    branch_EX = 1;
    pc_EX = 16'd41;
    branch_result_EX = 0;
    cycle();
    flush_req = 0;
    branch_EX = 0;
`ifdef BP_STATS_EN
    check("stat10_fl", stat_branches, 10);
    check("stat3_fl", stat_mispredicts, 3);
`endif
    wait_ready("flush_run_lat");

    pc_IF = 16'd5;
    idle(2);
    br(5, 1);
    br(5, 1);
    pc_IF = 16'h0045;
    idle(1);
    check("alias45", {31'b0, branch_predict_ID}, 1);

    pc_IF = 16'd9;
    idle(2);
    for (int k = 0; k < 3; k++) begin
      br(9, 0);
      idle(1);
    end
    check("ctr9", {31'b0, branch_predict_ID}, 0);

    pc_IF = 16'd7;
    idle(2);
    pc_IF = 16'd3;
    br(3, 0);
    check("wfirst", {31'b0, branch_predict_ID}, 0);

    do_reset();
    idle(30);
    flush_req = 1;
    cycle();
    flush_req = 0;
    wait_ready("flush_init_lat");

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      pc_IF = 16'($urandom);
      pc_EX = 16'($urandom);
      branch_EX = 1'($urandom_range(0, 1));
      branch_result_EX = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0);
      flush_req = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
